// File: rtl/rle_encoder.sv
// Three-channel run-length encoder: packs runs of equal 8-bit pixels into
// {count,value} codes per row, one independent encoder per colour channel.
module rle_channel #(
  parameter int COLS = 128,
  parameter int ROWS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pix_valid,
  input  logic [7:0]  i_pix,
  input  logic        i_full,
  output logic        o_ready,
  output logic [15:0] o_code,
  output logic        o_code_valid,
  output logic        o_nr,
  output logic        o_done
);

  typedef enum logic {ACCUM, FLUSH} state_t;

  localparam logic [7:0] LAST_COL = 8'(COLS - 1);
  localparam logic [8:0] ROWS_N   = 9'(ROWS);

  state_t      r_state;
  logic [7:0]  r_cur, r_cnt, r_col, r_pend;
  logic [8:0]  r_row;
  logic [15:0] r_code;
  logic        r_vld, r_nr, r_done;

  state_t      w_state_n;
  logic [7:0]  w_cur_n, w_cnt_n, w_col_n, w_pend_n;
  logic [8:0]  w_row_n;
  logic        w_free, w_take, w_emit, w_emit_nr, w_consume;
  logic [15:0] w_emit_code;

  assign w_free    = !r_vld || !i_full;
  assign o_ready   = !r_done && (r_state == ACCUM) && w_free;
  assign w_take    = i_pix_valid && o_ready;
  assign w_consume = r_vld && !i_full;

  always_comb begin
    w_state_n   = r_state;
    w_cur_n     = r_cur;
    w_cnt_n     = r_cnt;
    w_col_n     = r_col;
    w_row_n     = r_row;
    w_pend_n    = r_pend;
    w_emit      = 1'b0;
    w_emit_code = 16'h0000;
    w_emit_nr   = 1'b0;
    if (r_state == FLUSH) begin
      if (w_free) begin
        w_emit      = 1'b1;
        w_emit_code = {8'd1, r_pend};
        w_emit_nr   = 1'b1;
        w_cnt_n     = 8'd0;
        w_col_n     = 8'd0;
        w_row_n     = r_row + 9'd1;
        w_state_n   = ACCUM;
      end
    end else if (w_take) begin
      if (r_col != LAST_COL) begin
        w_col_n = r_col + 8'd1;
        if (r_cnt == 8'd0) begin
          w_cur_n = i_pix;
          w_cnt_n = 8'd1;
        end else if (i_pix == r_cur && r_cnt != 8'hFF) begin
          w_cnt_n = r_cnt + 8'd1;
        end else begin
          w_emit      = 1'b1;
          w_emit_code = {r_cnt, r_cur};
          w_cur_n     = i_pix;
          w_cnt_n     = 8'd1;
        end
      end else if (r_cnt == 8'd0) begin
        w_emit      = 1'b1;
        w_emit_code = {8'd1, i_pix};
        w_emit_nr   = 1'b1;
        w_cur_n     = i_pix;
        w_col_n     = 8'd0;
        w_row_n     = r_row + 9'd1;
      end else if (i_pix == r_cur && r_cnt != 8'hFF) begin
        w_emit      = 1'b1;
        w_emit_code = {r_cnt + 8'd1, r_cur};
        w_emit_nr   = 1'b1;
        w_cnt_n     = 8'd0;
        w_col_n     = 8'd0;
        w_row_n     = r_row + 9'd1;
      end else begin
        // Row ends on a run break: close the open run now, last pixel next cycle
        w_emit      = 1'b1;
        w_emit_code = {r_cnt, r_cur};
        w_pend_n    = i_pix;
        w_state_n   = FLUSH;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ACCUM;
      r_cur   <= 8'd0;
      r_cnt   <= 8'd0;
      r_col   <= 8'd0;
      r_row   <= 9'd0;
      r_pend  <= 8'd0;
      r_code  <= 16'h0000;
      r_vld   <= 1'b0;
      r_nr    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cur   <= w_cur_n;
      r_cnt   <= w_cnt_n;
      r_col   <= w_col_n;
      r_row   <= w_row_n;
      r_pend  <= w_pend_n;
      if (w_emit) begin
        r_code <= w_emit_code;
        r_nr   <= w_emit_nr;
        r_vld  <= 1'b1;
      end else if (w_consume) begin
        r_vld <= 1'b0;
        r_nr  <= 1'b0;
      end
      // row already reads ROWS once the final row's last code was loaded
      if (w_consume && r_nr && r_row == ROWS_N) r_done <= 1'b1;
    end
  end

  assign o_code       = r_code;
  assign o_code_valid = r_vld;
  assign o_nr         = r_nr;
  assign o_done       = r_done;

endmodule

module rle_encoder #(
  parameter int COLS = 128,
  parameter int ROWS = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  pix_valid,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic [2:0]  ready,
  input  logic [2:0]  full,
  output logic [15:0] R_code,
  output logic [15:0] G_code,
  output logic [15:0] B_code,
  output logic [2:0]  code_valid,
  output logic [2:0]  NR,
  output logic [2:0]  done
);

  rle_channel #(.COLS(COLS), .ROWS(ROWS)) u_r (
    .clk(clk), .rst(rst), .i_pix_valid(pix_valid[0]), .i_pix(R), .i_full(full[0]),
    .o_ready(ready[0]), .o_code(R_code), .o_code_valid(code_valid[0]),
    .o_nr(NR[0]), .o_done(done[0])
  );

  rle_channel #(.COLS(COLS), .ROWS(ROWS)) u_g (
    .clk(clk), .rst(rst), .i_pix_valid(pix_valid[1]), .i_pix(G), .i_full(full[1]),
    .o_ready(ready[1]), .o_code(G_code), .o_code_valid(code_valid[1]),
    .o_nr(NR[1]), .o_done(done[1])
  );

  rle_channel #(.COLS(COLS), .ROWS(ROWS)) u_b (
    .clk(clk), .rst(rst), .i_pix_valid(pix_valid[2]), .i_pix(B), .i_full(full[2]),
    .o_ready(ready[2]), .o_code(B_code), .o_code_valid(code_valid[2]),
    .o_nr(NR[2]), .o_done(done[2])
  );

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: per-cycle vector table on the R channel of a
// 4-column image, plus hand sequences for run cap, async reset and independence.
module tb_rle_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  pix_valid = 3'b000;
  logic [7:0]  R = 8'd0, G = 8'd0, B = 8'd0;
  logic [2:0]  full = 3'b000;

  logic [2:0]  a_ready, a_cv, a_nr, a_done;
  logic [15:0] a_rc, a_gc, a_bc;
  logic [2:0]  b_ready, b_cv, b_nr, b_done;
  logic [15:0] b_rc, b_gc, b_bc;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rle_encoder #(.COLS(4), .ROWS(1)) dut4 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .R(R), .G(G), .B(B),
    .ready(a_ready), .full(full), .R_code(a_rc), .G_code(a_gc), .B_code(a_bc),
    .code_valid(a_cv), .NR(a_nr), .done(a_done)
  );

  rle_encoder #(.COLS(256), .ROWS(1)) dut256 (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .R(R), .G(G), .B(B),
    .ready(b_ready), .full(full), .R_code(b_rc), .G_code(b_gc), .B_code(b_bc),
    .code_valid(b_cv), .NR(b_nr), .done(b_done)
  );

  typedef struct {
    bit         rs;   // apply reset before this vector
    bit         pv;
    logic [7:0] p;
    bit         f;
    bit         ev;   // expected code_valid[0]
    logic [15:0] ec;
    bit         en;
    bit         er;   // expected ready[0]
    bit         ed;   // expected done[0]
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rs, bit pv, logic [7:0] p, bit f, bit ev,
                              logic [15:0] ec, bit en, bit er, bit ed);
    vec_t v;
    v.rs = rs; v.pv = pv; v.p = p; v.f = f; v.ev = ev;
    v.ec = ec; v.en = en; v.er = er; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pix_valid = 3'b000;
    full = 3'b000;
    R = 8'd0; G = 8'd0; B = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  logic [15:0] gq_code[$];
  logic        gq_nr[$];
  logic [7:0]  gpix[4];
  logic [7:0]  bpix[4];
  int          g_idx, b_idx, g_wait;
  bit          g_acc, b_acc, r_bad, b_bad;

  initial begin
    // ---- table: four solid pixels, done, ignored pixel afterwards
    tbl.push_back(mk(1, 1, 8'd5, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd5, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd5, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd5, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'd0, 0, 1, 16'h0405, 1, 1, 0));
    tbl.push_back(mk(0, 1, 8'd9, 0, 0, 16'h0000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 0, 0, 16'h0000, 0, 0, 1));
    // ---- 1,2,2,3 unstalled: FLUSH cycle has ready low
    tbl.push_back(mk(1, 1, 8'd1, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd2, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd2, 0, 1, 16'h0101, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd3, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'd0, 0, 1, 16'h0202, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'd0, 0, 1, 16'h0103, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'd0, 0, 0, 16'h0000, 0, 0, 1));
    // ---- same stream with stalls on 0x0101 (pixel held) and on 0x0202
    tbl.push_back(mk(1, 1, 8'd1, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd2, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd2, 1, 1, 16'h0101, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'd2, 1, 1, 16'h0101, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'd2, 0, 1, 16'h0101, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'd3, 0, 0, 16'h0000, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1, 16'h0202, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1, 16'h0202, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1, 16'h0202, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'd0, 0, 1, 16'h0202, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'd0, 0, 1, 16'h0103, 1, 1, 0));
    tbl.push_back(mk(0, 0, 8'd0, 0, 0, 16'h0000, 0, 0, 1));

    // reset state
    #2;
    chk("rst_code_valid", {13'd0, a_cv}, 16'd0);
    chk("rst_R_code", a_rc, 16'h0000);
    chk("rst_NR", {13'd0, a_nr}, 16'd0);
    chk("rst_done", {13'd0, a_done}, 16'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rs) begin
        do_reset();
        chk("ready_after_rst", {13'd0, a_ready}, 16'h0007);
      end
      pix_valid = {2'b00, tbl[i].pv};
      R = tbl[i].p;
      full = {2'b00, tbl[i].f};
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {15'd0, a_cv[0]}, {15'd0, tbl[i].ev});
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_code", i), a_rc, tbl[i].ec);
        chk($sformatf("vec%0d_nr", i), {15'd0, a_nr[0]}, {15'd0, tbl[i].en});
      end
      chk($sformatf("vec%0d_ready", i), {15'd0, a_ready[0]}, {15'd0, tbl[i].er});
      chk($sformatf("vec%0d_done", i), {15'd0, a_done[0]}, {15'd0, tbl[i].ed});
      @(posedge clk);
      #1;
    end

    // ---- run cap on a 256-column row of 0x7F
    do_reset();
    R = 8'h7F;
    pix_valid = 3'b001;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk($sformatf("cap_novalid%0d", i), {15'd0, b_cv[0]}, 16'd0);
      chk($sformatf("cap_ready%0d", i), {15'd0, b_ready[0]}, 16'd1);
      @(posedge clk);
      #1;
    end
    pix_valid = 3'b000;
    @(negedge clk);
    chk("cap_code255", b_rc, 16'hFF7F);
    chk("cap_valid255", {15'd0, b_cv[0]}, 16'd1);
    chk("cap_nr255", {15'd0, b_nr[0]}, 16'd0);
    chk("cap_flush_ready", {15'd0, b_ready[0]}, 16'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("cap_code1", b_rc, 16'h017F);
    chk("cap_nr1", {15'd0, b_nr[0]}, 16'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("cap_done", {15'd0, b_done[0]}, 16'd1);
    @(posedge clk);
    #1;

    // ---- asynchronous reset mid-row while a code is presented
    do_reset();
    pix_valid = 3'b001;
    R = 8'd7;
    @(posedge clk);
    #1 R = 8'd8;
    @(posedge clk);
    #1 pix_valid = 3'b000;
    @(negedge clk);
    chk("mid_code_pre", a_rc, 16'h0107);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", {13'd0, a_cv}, 16'd0);
    chk("mid_rst_code", a_rc, 16'h0000);
    chk("mid_rst_nr", {13'd0, a_nr}, 16'd0);
    chk("mid_rst_done", {13'd0, a_done}, 16'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    pix_valid = 3'b001;
    R = 8'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("mid_novalid%0d", i), {15'd0, a_cv[0]}, 16'd0);
      @(posedge clk);
      #1;
    end
    pix_valid = 3'b000;
    @(negedge clk);
    chk("mid_code", a_rc, 16'h0409);
    chk("mid_nr", {15'd0, a_nr[0]}, 16'd1);
    chk("mid_valid", {15'd0, a_cv[0]}, 16'd1);
    @(posedge clk);
    #1;

    // ---- independence: G throttled, B stalled, R idle
    do_reset();
    gpix = '{8'd1, 8'd2, 8'd2, 8'd3};
    bpix = '{8'd4, 8'd4, 8'd5, 8'd5};
    g_idx = 0; b_idx = 0; g_wait = 0; r_bad = 0; b_bad = 0;
    full = 3'b100;
    for (int cyc = 0; cyc < 36; cyc++) begin
      pix_valid[0] = 1'b0;
      pix_valid[1] = (g_idx < 4) && (g_wait == 0);
      G = (g_idx < 4) ? gpix[g_idx] : 8'd0;
      pix_valid[2] = (b_idx < 4);
      B = (b_idx < 4) ? bpix[b_idx] : 8'd0;
      @(negedge clk);
      g_acc = pix_valid[1] && a_ready[1];
      b_acc = pix_valid[2] && a_ready[2];
      if (a_cv[1] && !full[1]) begin
        gq_code.push_back(a_gc);
        gq_nr.push_back(a_nr[1]);
      end
      if (a_cv[0]) r_bad = 1;
      if (a_cv[2] && a_bc != 16'h0204) b_bad = 1;
      @(posedge clk);
      #1;
      if (g_acc) begin
        g_idx++;
        g_wait = 2;
      end else if (g_wait > 0) begin
        g_wait--;
      end
      if (b_acc) b_idx++;
    end
    chk("ind_g_count", 16'(gq_code.size()), 16'd3);
    if (gq_code.size() == 3) begin
      chk("ind_g0", gq_code[0], 16'h0101);
      chk("ind_g1", gq_code[1], 16'h0202);
      chk("ind_g2", gq_code[2], 16'h0103);
      chk("ind_g0_nr", {15'd0, gq_nr[0]}, 16'd0);
      chk("ind_g1_nr", {15'd0, gq_nr[1]}, 16'd0);
      chk("ind_g2_nr", {15'd0, gq_nr[2]}, 16'd1);
    end
    chk("ind_g_done", {15'd0, a_done[1]}, 16'd1);
    chk("ind_r_idle", {15'd0, r_bad}, 16'd0);
    chk("ind_b_held", {15'd0, b_bad}, 16'd0);
    chk("ind_b_accepted", 16'(b_idx), 16'd3);
    chk("ind_b_valid", {15'd0, a_cv[2]}, 16'd1);
    chk("ind_b_code", a_bc, 16'h0204);
    chk("ind_b_ready", {15'd0, a_ready[2]}, 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
